// File: rtl/alu_pkg.sv
// Shared definitions for the iterative MIPS ALU.
// Op codes, FSM encoding and divide-by-zero fill.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_LUI   = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_SLL   = 4'b1001;
  localparam logic [3:0] OP_SRL   = 4'b1010;
  localparam logic [3:0] OP_SRA   = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_MULT  = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_DIV   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  // Every bit of a divide-by-zero quotient takes this value.
  localparam logic DBZ_FILL = 1'b1;

endpackage

// File: rtl/muldiv_engine.sv
// Iterative shift-add multiplier / restoring divider.
// One bit per cycle, sign fix-up on the last step.
module muldiv_engine
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mc_q, acc_q, lo_q;
  logic [CW-1:0]      cnt_q;
  logic               run_q, div_q, nlo_q, nhi_q;
  logic               sgn, sa, sb, dv, last;
  logic [WIDTH-1:0]   ma, mb, it_acc, it_lo;
  logic [WIDTH:0]     add, sum, shf, dif;
  logic [2*WIDTH-1:0] prod;

  // Operand magnitudes and signs for the op being started.
  always_comb begin
    sgn = (op == OP_MULT) || (op == OP_DIV);
    dv  = (op == OP_DIVU) || (op == OP_DIV);
    sa  = sgn & a[WIDTH-1];
    sb  = sgn & b[WIDTH-1];
    ma  = sa ? '0 - a : a;
    mb  = sb ? '0 - b : b;
  end

  // One multiply or divide step on the current state.
  always_comb begin
    add = lo_q[0] ? {1'b0, mc_q} : '0;
    sum = {1'b0, acc_q} + add;
    shf = {acc_q, lo_q[WIDTH-1]};
    dif = shf - {1'b0, mc_q};
    if (div_q) begin
      if (dif[WIDTH]) begin
        it_acc = shf[WIDTH-1:0];
        it_lo  = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        it_acc = dif[WIDTH-1:0];
        it_lo  = {lo_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      it_acc = sum[WIDTH:1];
      it_lo  = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Sign correction applied to the final step's value.
  always_comb begin
    prod = {it_acc, it_lo};
    if (nlo_q) prod = '0 - prod;
    hi = prod[2*WIDTH-1:WIDTH];
    lo = prod[WIDTH-1:0];
    if (div_q) begin
      lo = nlo_q ? '0 - it_lo : it_lo;
      hi = nhi_q ? '0 - it_acc : it_acc;
    end
  end

  assign last = (cnt_q == CW'(WIDTH - 1));
  assign done = run_q & last;

  // Operand latch and iteration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_q  <= '0;
      acc_q <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      div_q <= 1'b0;
      nlo_q <= 1'b0;
      nhi_q <= 1'b0;
    end else if (start) begin
      mc_q  <= dv ? mb : ma;
      lo_q  <= dv ? ma : mb;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
      div_q <= dv;
      nlo_q <= sa ^ sb;
      nhi_q <= dv & sa;
    end else if (run_q) begin
      acc_q <= it_acc;
      lo_q  <= it_lo;
      cnt_q <= cnt_q + 1'b1;
      if (last) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Handshaked MIPS ALU: single-cycle ops plus
// iterative multiply/divide with HI/LO results.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf,
  output logic             dbz
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d;
  logic             zero_q, zero_d, ovf_q, ovf_d;
  logic             dbz_q, dbz_d;
  logic             start, ld, is_md, is_div, b_zero;
  logic [WIDTH-1:0] sum, dif, alu_r, eng_lo, eng_hi;
  logic             alu_ovf, eng_done;
  logic [SHAMT_W-1:0] sh;

  assign sum    = a + b;
  assign dif    = a - b;
  assign sh     = a[SHAMT_W-1:0];
  assign is_md  = op[3] & op[2];
  assign is_div = is_md & op[1];
  assign b_zero = (b == '0);

  // Single-cycle result and overflow.
  always_comb begin
    alu_r   = '0;
    alu_ovf = 1'b0;
    unique case (op)
      OP_AND:  alu_r = a & b;
      OP_OR:   alu_r = a | b;
      OP_XOR:  alu_r = a ^ b;
      OP_NOR:  alu_r = ~(a | b);
      OP_ADD: begin
        alu_r   = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                  (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r   = dif;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                  (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_r[0] = $signed(a) < $signed(b);
      OP_SLTU: alu_r[0] = a < b;
      OP_LUI:  alu_r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLL:  alu_r = b << sh;
      OP_SRL:  alu_r = b >> sh;
      OP_SRA:  alu_r = $unsigned($signed(b) >>> sh);
      default: alu_r = '0;
    endcase
  end

  muldiv_engine #(.WIDTH(WIDTH)) u_md (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .done  (eng_done),
    .lo    (eng_lo),
    .hi    (eng_hi)
  );

  // Next state and output register loads.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    start   = 1'b0;
    ld      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_md && !(is_div && b_zero)) begin
            start   = 1'b1;
            state_d = S_BUSY;
          end else begin
            ld      = 1'b1;
            state_d = S_DONE;
            ovf_d   = 1'b0;
            dbz_d   = 1'b0;
            hi_d    = '0;
            if (is_md) begin
              res_d = {WIDTH{DBZ_FILL}};
              hi_d  = a;
              dbz_d = 1'b1;
            end else begin
              res_d = alu_r;
              ovf_d = alu_ovf;
            end
          end
        end
      end
      S_BUSY: begin
        if (eng_done) begin
          ld      = 1'b1;
          res_d   = eng_lo;
          hi_d    = eng_hi;
          ovf_d   = 1'b0;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (ld) zero_d = (res_d == '0);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_alu_iter.sv
// Randomised scoreboard bench for alu_iter.
// Reference model uses plain 64-bit arithmetic.
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result, hi;
  logic        zero, ovf, dbz;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] r;
    logic [31:0] h;
    logic        z;
    logic        o;
    logic        d;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   mode = 2;
  bit   seen = 0;

  alu_iter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .hi        (hi),
    .zero      (zero),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o,
                                 input logic [31:0] x,
                                 input logic [31:0] y);
    exp_t e;
    longint sa, sy, t;
    longint unsigned ua, uy;
    logic [63:0] p;
    logic signed [31:0] ys;
    sa = longint'($signed(x));
    sy = longint'($signed(y));
    ua = {32'h0, x};
    uy = {32'h0, y};
    ys = y;
    e.op = o; e.r = '0; e.h = '0;
    e.o = 0; e.d = 0; e.lat = 1; e.acc = 0;
    case (o)
      4'h0: e.r = x & y;
      4'h1: e.r = x | y;
      4'h4: e.r = x ^ y;
      4'h5: e.r = ~(x | y);
      4'h2, 4'h6: begin
        t = (o == 4'h2) ? sa + sy : sa - sy;
        p = t;
        e.r = p[31:0];
        e.o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      4'h7: e.r = {31'h0, sa < sy};
      4'h8: e.r = {31'h0, ua < uy};
      4'h3: e.r = y * 32'h10000;
      4'h9: e.r = y << x[4:0];
      4'hA: e.r = y >> x[4:0];
      4'hB: e.r = ys >>> x[4:0];
      4'hC, 4'hD: begin
        p = (o == 4'hC) ? ua * uy : sa * sy;
        e.r = p[31:0];
        e.h = p[63:32];
        e.lat = 33;
      end
      default: begin
        if (y == 0) begin
          e.r = 32'hFFFFFFFF;
          e.h = x;
          e.d = 1;
        end else begin
          e.lat = 33;
          if (o == 4'hE) begin
            e.r = x / y;
            e.h = x % y;
          end else begin
            p = sa / sy;
            e.r = p[31:0];
            p = sa % sy;
            e.h = p[31:0];
          end
        end
      end
    endcase
    e.z = (e.r == 0);
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [3:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y);
    exp_t e;
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    op = o; a = x; b = y;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_wait", {63'h0, in_ready}, 64'h1);
      in_valid = 1'b0;
      return;
    end
    e = model(o, x, y);
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  // Scoreboard monitor: latency on first valid,
  // value check on the handshake.
  always @(negedge clk) begin
    exp_t e;
    case (mode)
      0: out_ready = ($urandom_range(0, 3) != 0);
      1: out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
    if (!rst_n) begin
      seen = 0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", {63'h0, out_valid}, 64'h0);
      end else begin
        e = sb[0];
        if (!seen) begin
          chk($sformatf("lat op%0h", e.op),
              64'(cyc - e.acc), 64'(e.lat));
          seen = 1;
        end
        if (out_ready) begin
          chk($sformatf("res op%0h", e.op), {32'h0, result}, {32'h0, e.r});
          chk($sformatf("hi op%0h", e.op), {32'h0, hi}, {32'h0, e.h});
          chk($sformatf("flags op%0h", e.op),
              {61'h0, zero, ovf, dbz}, {61'h0, e.z, e.o, e.d});
          void'(sb.pop_front());
          seen = 0;
        end
      end
    end
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out", {out_valid, zero, ovf, dbz, result, hi},
        {4'h0, 32'h0, 32'h0});
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_ready", {62'h0, in_ready, out_valid}, 64'h2);

    issue(4'h2, 32'h7FFFFFFF, 32'h1);
    issue(4'h7, 32'hFFFFFFFF, 32'h1);
    issue(4'h8, 32'hFFFFFFFF, 32'h1);
    issue(4'h3, 32'hABCD, 32'h1234);
    issue(4'hD, 32'hFFFFFFFD, 32'h7);
    issue(4'hF, 32'hFFFFFFF9, 32'h2);
    issue(4'hE, 32'h5, 32'h0);
    issue(4'hF, 32'h80000000, 32'hFFFFFFFF);
    issue(4'hC, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(4'h6, 32'h80000000, 32'h1);
    issue(4'hB, 32'h4, 32'h80000000);

    // backpressure on SUB 5-5
    @(negedge clk);
    #1 mode = 1;
    issue(4'h6, 32'h5, 32'h5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("bp_hold", {out_valid, zero, in_ready, result},
          {3'b110, 32'h0});
    end
    mode = 2;
    @(negedge clk);
    #1 chk("bp_ready_lo", {63'h0, in_ready}, 64'h0);
    @(negedge clk);
    #1 chk("bp_ready_hi", {63'h0, in_ready}, 64'h1);

    // random traffic with random backpressure
    mode = 0;
    for (int i = 0; i < 150; i++) begin
      issue(4'($urandom_range(0, 15)), pick(), pick());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // drain, then reset in the middle of a divide
    mode = 2;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain1", 64'(sb.size()), 64'h0);
    issue(4'hE, 32'd100, 32'd7);
    repeat (11) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out", {out_valid, zero, ovf, dbz, result, hi},
        {4'h0, 32'h0, 32'h0});
    sb.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1 if (out_valid) n++;
    end
    chk("abort_no_valid", 64'(n), 64'h0);
    chk("abort_ready", {63'h0, in_ready}, 64'h1);
    issue(4'h2, 32'd2, 32'd3);

    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain2", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
Parametrised, handshaked successor to the single-cycle ALU for the MIPS datapath. It keeps the existing logic, arithmetic, SLT and LUI ops and adds XOR/NOR/SLTU, shifts, and iterative multiply/divide that write HI/LO-style dual results. Operands enter on a valid/ready handshake and results leave on a second valid/ready handshake. This lets the control unit stall on multi-cycle operations.

Parameters:
WIDTH, 32, operand/result width in bits; even, at least 4
SHAMT_W, 5, shift-amount bits taken from a; equals clog2(WIDTH)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands/op presented
in_ready  out  1  block can accept an operation
op  in  4  operation code
a  in  WIDTH  operand 1 (register data1)
b  in  WIDTH  operand 2 (ALU mux output)
out_valid  out  1  result valid
out_ready  in  1  consumer takes result
result  out  WIDTH  primary result / LO / quotient
hi  out  WIDTH  product upper half / remainder; 0 for other ops
zero  out  1  result == 0
ovf  out  1  signed overflow (ADD/SUB only)
dbz  out  1  divide by zero (DIV/DIVU only)

Behaviour:
- Reset (async, rst_n low): state IDLE; in_ready=1 when rst_n is released; out_valid, result, hi, zero, ovf and dbz are all 0. Reset during BUSY or DONE aborts the operation; no result is ever emitted.
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
  - 0111 SLT (signed), 1000 SLTU. SLT/SLTU give 1 or 0.
  - 0011 LUI = {b[WIDTH/2-1:0], WIDTH/2 zeros}.
  - 0100 XOR, 0101 NOR.
  - 1001 SLL, 1010 SRL, 1011 SRA. Each shifts b by a[SHAMT_W-1:0].
  - 1100 MULTU, 1101 MULT, 1110 DIVU, 1111 DIV.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH. ovf is set when the operand signs match (ADD) or differ (SUB) and the result sign differs from a.
- FSM states: IDLE, BUSY, DONE. in_ready is 1 only in IDLE. An operation is accepted when in_valid and in_ready are both 1.
  - IDLE, single-cycle op accepted: register outputs and go to DONE. out_valid rises the next cycle (latency 1).
  - IDLE, mul/div op accepted: latch magnitudes and signs, clear the counter, go to BUSY.
  - BUSY runs exactly WIDTH iterations.
    - Multiply: shift-add, one bit per cycle.
    - Divide: restoring, one quotient bit per cycle.
  - After the last iteration, apply sign correction and go to DONE. Total latency from accept to out_valid is WIDTH+1 cycles.
  - DONE: out_valid=1. result, hi and the flags stay stable until out_ready=1; then go to IDLE.
  - Result-to-next-op latency: in_ready rises the cycle after the out_ready handshake.
- MULT/MULTU: {hi,result} is the full 2*WIDTH product. MULT multiplies magnitudes, then negates the 2*WIDTH product if the operand signs differ.
- DIV/DIVU: result is the quotient, hi the remainder. For DIV, the quotient sign is sign(a) XOR sign(b) and the remainder takes the sign of a (truncating division).
  - Signed minimum / -1: result = signed minimum, hi = 0, ovf = 0.
- Divide by zero (b=0): skips BUSY and goes straight to DONE with latency 1. Outputs: result = all ones, hi = a, dbz = 1.
- zero is computed from the registered result for every op.
- ovf and dbz are 0 for every op they do not apply to.
- hi is 0 for every single-cycle op.
- in_valid is ignored whenever in_ready is 0. Inputs are sampled only at acceptance, so they may change during BUSY.

Decomposition:
- Package alu_pkg holds:
  - op-code localparams (OP_AND through OP_DIV);
  - the state encoding (IDLE/BUSY/DONE);
  - the divide-by-zero result constant.
- One sub-module, muldiv_engine, owns the iterative datapath. It contains the accumulator, the partial-remainder and quotient registers, the iteration counter and the sign-correction logic. Its interface is start/op/a/b in and done/lo/hi out.
- alu_iter holds the FSM, the combinational single-cycle ops, the flags and the handshake.

Test Plan:
- ADD a=0x7FFFFFFF, b=1, out_ready=1 -> one cycle later out_valid=1, result=0x80000000, ovf=1, zero=0.
- SLT a=0xFFFFFFFF, b=1 -> result=1; SLTU with the same operands -> result=0. LUI b=0x1234 -> result=0x12340000.
- MULT a=-3 (0xFFFFFFFD), b=7 -> out_valid exactly 33 cycles after accept; hi=0xFFFFFFFF, result=0xFFFFFFEB.
- DIV a=-7, b=2 -> result=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=5, b=0 -> latency 1, result=0xFFFFFFFF, hi=5, dbz=1.
- Backpressure: hold out_ready=0 for 10 cycles after a SUB 5-5 -> result=0 and zero=1 stay stable, in_ready=0 throughout. Raise out_ready -> in_ready=1 the next cycle.
- Reset: assert rst_n=0 at iteration 12 of a DIVU 100/7 -> all outputs 0 immediately, no out_valid after release. A fresh ADD 2+3 then gives result=5.
